io_uart_in: RTL and testbench
=============================

IO_UART_IN -- requirements
Module: io_uart_in

Interface
REQ-001 Parameter FIFO_AW, default 4, log2 of RX FIFO depth (16 entries × 8 bit).
REQ-002 Parameter ADR_DATA, default 14'h3C10, word address of RXDATA register.
REQ-003 Parameter ADR_STAT, default 14'h3C11, word address of RXSTAT register.
REQ-004 Parameter ADR_CTRL, default 14'h3C12, word address of RXCTRL register.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 dma_io_we  in  1  IO write strobe.
REQ-008 dma_io_wadr  in  14 [15:2]  IO write word address.
REQ-009 dma_io_wdata  in  32  IO write data.
REQ-010 dma_io_radr  in  14 [15:2]  IO read word address.
REQ-011 dma_io_radr_en  in  1  IO read strobe.
REQ-012 dma_io_rdata_in  in  32  read data from upstream IO device in chain.
REQ-013 dma_io_rdata  out  32  chained read data to CPU.
REQ-014 uart_in_char  in  8  received byte from UART receiver.
REQ-015 uart_in_we  in  1  one-cycle strobe: uart_in_char valid.
REQ-016 uart_in_full  out  1  FIFO full; receiver backpressure indication.
REQ-017 uart_in_int  out  1  level interrupt request to CPU.

Function
REQ-018 uart_in_we with FIFO not full SHALL push uart_in_char; with FIFO full and no same-cycle pop SHALL drop byte and set sticky overrun.
REQ-019 IO read (dma_io_radr_en, dma_io_radr==ADR_DATA) SHALL return {23'd0, valid, byte}; valid=1 and FIFO head popped when non-empty; all-zero, no pop, when empty.
REQ-020 RXSTAT read SHALL return {19'd0, count[4:0], 5'd0, overrun, full, ~empty}; no side effects.
REQ-021 RXCTRL read SHALL return {31'd0, int_en}.
REQ-022 dma_io_rdata SHALL be registered: selected data valid cycle N+1 after strobe at cycle N, OR'd with dma_io_rdata_in; own contribution zero when not addressed.
REQ-023 Write to ADR_CTRL SHALL load int_en from wdata[0]; bit[1]=1 SHALL flush FIFO (count 0, pointers 0).
REQ-024 Write to ADR_STAT with wdata[2]=1 SHALL clear overrun; other writes ignored.
REQ-025 Simultaneous push and pop SHALL both occur, count unchanged, including at full (no overrun) and at empty (push only; read returns empty).
REQ-026 Overrun set and clear in same cycle: set wins.
REQ-027 Flush and push in same cycle: flush wins, byte discarded, overrun unaffected.
REQ-028 Pointers SHALL wrap modulo 2^FIFO_AW; count width FIFO_AW+1.
REQ-029 uart_in_full SHALL equal (count==2^FIFO_AW), registered state, no combinational path from inputs.
REQ-030 uart_in_int SHALL equal int_en & (~empty | overrun), registered.

Reset
REQ-031 rst_n low SHALL immediately clear pointers, count, overrun, int_en, dma_io_rdata, uart_in_int (all 0); uart_in_full 0; FIFO storage not reset.
REQ-032 Reset mid-read SHALL abort pending read data; first cycle after release shall return 0.

Structure
REQ-033 Register word addresses and RXSTAT bit positions SHALL live in shared package io_map_pkg.
REQ-034 Storage SHALL be a sub-module io_sync_fifo (parameterised width/depth, push/pop/flush, count); io_uart_in holds register decode and read mux.

Verification
REQ-035 Push 0x41,0x42; read ADR_DATA twice, third time -> 0x141, 0x142, then 0x000; RXSTAT bit0 0.
REQ-036 Push 17 bytes with no reads -> uart_in_full=1 after 16th, RXSTAT=0x1000|0x7 (count 16, overrun, full, ne); 17th byte never returned.
REQ-037 At full, push 0x55 and pop in same cycle -> pop returns first byte, count stays 16, overrun 0, 0x55 last out.
REQ-038 int_en=1, push one byte -> uart_in_int 1; read ADR_DATA -> uart_in_int 0 on next cycle.
REQ-039 dma_io_rdata_in=0x80000000, read RXSTAT when empty -> dma_io_rdata=0x80000000; read unmapped address -> passthrough only.
REQ-040 Push 3 bytes, assert rst_n low mid-read -> dma_io_rdata 0, count 0, uart_in_full 0 after release.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared IO map for the UART receive block: register word addresses,
// RXSTAT/RXCTRL bit positions and the RXSTAT word packer.
package io_map_pkg;

  localparam logic [13:0] ADR_RXDATA = 14'h3C10;
  localparam logic [13:0] ADR_RXSTAT = 14'h3C11;
  localparam logic [13:0] ADR_RXCTRL = 14'h3C12;

  localparam int STAT_NE_BIT   = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVR_BIT  = 2;
  localparam int STAT_CNT_LSB  = 8;
  localparam int STAT_CNT_W    = 5;

  localparam int CTRL_INT_EN_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;

  function automatic logic [31:0] rxstat_word(input logic [STAT_CNT_W-1:0] cnt,
                                              input logic ovr,
                                              input logic full,
                                              input logic ne);
    logic [31:0] w;
    w = 32'd0;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    w[STAT_OVR_BIT]  = ovr;
    w[STAT_FULL_BIT] = full;
    w[STAT_NE_BIT]   = ne;
    return w;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with push/pop/flush and occupancy count; head is
// presented combinationally from storage, full is held in a register.
module io_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic [AW:0]   count_nx,
  output logic          empty,
  output logic          full
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [W-1:0]  mem_r [2**AW];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_nx_s;
  logic          full_r, do_push_s, do_pop_s;

  // A pop frees a slot in the same cycle, so a push at full still lands.
  assign do_pop_s  = pop & (count_r != {(AW+1){1'b0}}) & ~flush;
  assign do_push_s = push & (~full_r | do_pop_s) & ~flush;

  always_comb begin
    count_nx_s = count_r;
    if (flush) begin
      count_nx_s = {(AW+1){1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_nx_s = count_r + ONE;
        2'b01:   count_nx_s = count_r - ONE;
        default: count_nx_s = count_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_nx_s;
      full_r  <= (count_nx_s == DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata    = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign count_nx = count_nx_s;
  assign empty    = (count_r == {(AW+1){1'b0}});
  assign full     = full_r;

endmodule

// File: rtl/io_uart_in.sv
// UART receive IO device: RX FIFO behind RXDATA/RXSTAT/RXCTRL registers,
// chained registered read bus, overrun tracking and level interrupt.
module io_uart_in
  import io_map_pkg::*;
#(
  parameter int          FIFO_AW  = 4,
  parameter logic [13:0] ADR_DATA = ADR_RXDATA,
  parameter logic [13:0] ADR_STAT = ADR_RXSTAT,
  parameter logic [13:0] ADR_CTRL = ADR_RXCTRL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic [7:0]  uart_in_char,
  input  logic        uart_in_we,
  output logic        uart_in_full,
  output logic        uart_in_int
);

  localparam int CW = FIFO_AW + 1;

  logic          rd_data_s, rd_stat_s, rd_ctrl_s, wr_stat_s, wr_ctrl_s;
  logic          flush_s, pop_s, empty_s, full_s;
  logic [7:0]    head_s;
  logic [CW-1:0] count_s, count_nx_s;
  logic          ovr_r, ovr_nx_s, int_en_r, int_en_nx_s, int_r;
  logic [31:0]   own_s, rdata_r;
  logic          unused_wdata_s;

  assign rd_data_s = dma_io_radr_en & (dma_io_radr == ADR_DATA);
  assign rd_stat_s = dma_io_radr_en & (dma_io_radr == ADR_STAT);
  assign rd_ctrl_s = dma_io_radr_en & (dma_io_radr == ADR_CTRL);
  assign wr_stat_s = dma_io_we & (dma_io_wadr == ADR_STAT);
  assign wr_ctrl_s = dma_io_we & (dma_io_wadr == ADR_CTRL);
  assign flush_s   = wr_ctrl_s & dma_io_wdata[CTRL_FLUSH_BIT];
  assign pop_s     = rd_data_s & ~empty_s;
  assign unused_wdata_s = ^dma_io_wdata[31:3];

  io_sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (uart_in_we),
    .pop      (pop_s),
    .flush    (flush_s),
    .wdata    (uart_in_char),
    .rdata    (head_s),
    .count    (count_s),
    .count_nx (count_nx_s),
    .empty    (empty_s),
    .full     (full_s)
  );

  // Overrun set beats a same-cycle clear; a flush swallows the byte silently.
  always_comb begin
    ovr_nx_s = ovr_r;
    if (uart_in_we & full_s & ~pop_s & ~flush_s) begin
      ovr_nx_s = 1'b1;
    end else if (wr_stat_s & dma_io_wdata[STAT_OVR_BIT]) begin
      ovr_nx_s = 1'b0;
    end else begin
      ovr_nx_s = ovr_r;
    end
    int_en_nx_s = wr_ctrl_s ? dma_io_wdata[CTRL_INT_EN_BIT] : int_en_r;
  end

  always_comb begin
    own_s = 32'd0;
    if (rd_data_s) begin
      own_s = empty_s ? 32'd0 : {23'd0, 1'b1, head_s};
    end else if (rd_stat_s) begin
      own_s = rxstat_word(STAT_CNT_W'(count_s), ovr_r, full_s, ~empty_s);
    end else if (rd_ctrl_s) begin
      own_s = {31'd0, int_en_r};
    end else begin
      own_s = 32'd0;
    end
  end

  // Interrupt is built from next-state values so it tracks the FIFO exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_r    <= 1'b0;
      int_en_r <= 1'b0;
      int_r    <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      ovr_r    <= ovr_nx_s;
      int_en_r <= int_en_nx_s;
      int_r    <= int_en_nx_s & ((count_nx_s != {CW{1'b0}}) | ovr_nx_s);
      rdata_r  <= own_s | dma_io_rdata_in;
    end
  end

  assign dma_io_rdata = rdata_r;
  assign uart_in_full = full_s;
  assign uart_in_int  = int_r;

endmodule

// File: tb/tb_io_uart_in.sv
// Self-checking bench for io_uart_in: directed scenarios plus randomized
// traffic against a queue-based reference model of the receive device.
module tb_io_uart_in;

  localparam logic [13:0] A_DATA = 14'h3C10;
  localparam logic [13:0] A_STAT = 14'h3C11;
  localparam logic [13:0] A_CTRL = 14'h3C12;

  logic        clk, rst_n;
  logic        dma_io_we, dma_io_radr_en, uart_in_we;
  logic [13:0] dma_io_wadr, dma_io_radr;
  logic [31:0] dma_io_wdata, dma_io_rdata_in, dma_io_rdata;
  logic [7:0]  uart_in_char;
  logic        uart_in_full, uart_in_int;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  q[$];
  logic        m_ovr, m_int_en;
  logic [31:0] exp_rdata;
  logic        exp_full, exp_int;

  io_uart_in dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dma_io_we       (dma_io_we),
    .dma_io_wadr     (dma_io_wadr),
    .dma_io_wdata    (dma_io_wdata),
    .dma_io_radr     (dma_io_radr),
    .dma_io_radr_en  (dma_io_radr_en),
    .dma_io_rdata_in (dma_io_rdata_in),
    .dma_io_rdata    (dma_io_rdata),
    .uart_in_char    (uart_in_char),
    .uart_in_we      (uart_in_we),
    .uart_in_full    (uart_in_full),
    .uart_in_int     (uart_in_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_ovr = 1'b0;
    m_int_en = 1'b0;
    exp_rdata = 32'd0;
    exp_full = 1'b0;
    exp_int = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the reference model across the edge.
  task automatic tick(input logic we, input logic [13:0] wadr, input logic [31:0] wdata,
                      input logic re, input logic [13:0] radr,
                      input logic uwe, input logic [7:0] ch);
    logic [31:0] own;
    logic popq, flush, ovr_set;
    dma_io_we = we; dma_io_wadr = wadr; dma_io_wdata = wdata;
    dma_io_radr_en = re; dma_io_radr = radr;
    uart_in_we = uwe; uart_in_char = ch;
    own = 32'd0;
    popq = re && (radr == A_DATA) && (q.size() > 0);
    if (re) begin
      if (radr == A_DATA) own = (q.size() > 0) ? {23'd0, 1'b1, q[0]} : 32'd0;
      else if (radr == A_STAT)
        own = {19'd0, 5'(q.size()), 5'd0, m_ovr, q.size() == 16, q.size() != 0};
      else if (radr == A_CTRL) own = {31'd0, m_int_en};
    end
    exp_rdata = own | dma_io_rdata_in;
    @(posedge clk);
    flush = we && (wadr == A_CTRL) && wdata[1];
    ovr_set = 1'b0;
    if (flush) q.delete();
    else begin
      if (popq) void'(q.pop_front());
      if (uwe) begin
        if (q.size() < 16) q.push_back(ch);
        else ovr_set = 1'b1;
      end
    end
    if (ovr_set) m_ovr = 1'b1;
    else if (we && (wadr == A_STAT) && wdata[2]) m_ovr = 1'b0;
    if (we && (wadr == A_CTRL)) m_int_en = wdata[0];
    exp_full = (q.size() == 16);
    exp_int  = m_int_en && ((q.size() != 0) || m_ovr);
    #1;
    dma_io_we = 1'b0; dma_io_radr_en = 1'b0; uart_in_we = 1'b0;
  endtask

  task automatic push(input logic [7:0] ch);
    tick(1'b0, 14'd0, 32'd0, 1'b0, 14'd0, 1'b1, ch);
  endtask

  task automatic rd(input logic [13:0] adr);
    tick(1'b0, 14'd0, 32'd0, 1'b1, adr, 1'b0, 8'd0);
  endtask

  task automatic wr(input logic [13:0] adr, input logic [31:0] d);
    tick(1'b1, adr, d, 1'b0, 14'd0, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dma_io_rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", dma_io_rdata); else n_pass++;
    n_checks++; if (uart_in_full !== 1'b0) $display("FAIL reset_full got %b want 0", uart_in_full); else n_pass++;
    n_checks++; if (uart_in_int !== 1'b0) $display("FAIL reset_int got %b want 0", uart_in_int); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'd0) $display("FAIL reset_stat got %h want 0", dma_io_rdata); else n_pass++;
  endtask

  task automatic test_basic();
    push(8'h41);
    push(8'h42);
    rd(A_DATA);
    n_checks++; if (dma_io_rdata !== 32'h141) $display("FAIL basic_rd1 got %h want 141", dma_io_rdata); else n_pass++;
    rd(A_DATA);
    n_checks++; if (dma_io_rdata !== 32'h142) $display("FAIL basic_rd2 got %h want 142", dma_io_rdata); else n_pass++;
    rd(A_DATA);
    n_checks++; if (dma_io_rdata !== 32'h000) $display("FAIL basic_rd_empty got %h want 0", dma_io_rdata); else n_pass++;
    rd(A_STAT);
    n_checks++; if (dma_io_rdata[0] !== 1'b0) $display("FAIL basic_stat_ne got %b want 0", dma_io_rdata[0]); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] b[17];
    for (int i = 0; i < 17; i++) begin
      b[i] = 8'($urandom);
      push(b[i]);
      if (i == 15) begin
        n_checks++; if (uart_in_full !== 1'b1) $display("FAIL ovf_full16 got %b want 1", uart_in_full); else n_pass++;
      end
    end
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'h1007) $display("FAIL ovf_stat got %h want 1007", dma_io_rdata); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      rd(A_DATA);
      n_checks++; if (dma_io_rdata !== {23'd0, 1'b1, b[i]}) $display("FAIL ovf_drain%0d got %h want %h", i, dma_io_rdata, {23'd0, 1'b1, b[i]}); else n_pass++;
    end
    rd(A_DATA);
    n_checks++; if (dma_io_rdata !== 32'd0) $display("FAIL ovf_17th got %h want 0", dma_io_rdata); else n_pass++;
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'h4) $display("FAIL ovf_sticky got %h want 4", dma_io_rdata); else n_pass++;
    wr(A_STAT, 32'h4);
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'h0) $display("FAIL ovf_clear got %h want 0", dma_io_rdata); else n_pass++;
  endtask

  task automatic test_full_pushpop();
    logic [7:0] b[16];
    for (int i = 0; i < 16; i++) begin
      b[i] = 8'($urandom_range(0, 84));
      push(b[i]);
    end
    tick(1'b0, 14'd0, 32'd0, 1'b1, A_DATA, 1'b1, 8'h55);
    n_checks++; if (dma_io_rdata !== {23'd0, 1'b1, b[0]}) $display("FAIL fpp_pop got %h want %h", dma_io_rdata, {23'd0, 1'b1, b[0]}); else n_pass++;
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'h1003) $display("FAIL fpp_stat got %h want 1003", dma_io_rdata); else n_pass++;
    for (int i = 1; i < 16; i++) rd(A_DATA);
    n_checks++; if (dma_io_rdata !== {23'd0, 1'b1, b[15]}) $display("FAIL fpp_b15 got %h want %h", dma_io_rdata, {23'd0, 1'b1, b[15]}); else n_pass++;
    rd(A_DATA);
    n_checks++; if (dma_io_rdata !== 32'h155) $display("FAIL fpp_last got %h want 155", dma_io_rdata); else n_pass++;
  endtask

  task automatic test_corners();
    for (int i = 0; i < 16; i++) push(8'(i));
    tick(1'b1, A_STAT, 32'h4, 1'b0, 14'd0, 1'b1, 8'hEE);
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'h1007) $display("FAIL set_wins got %h want 1007", dma_io_rdata); else n_pass++;
    tick(1'b1, A_CTRL, 32'h2, 1'b0, 14'd0, 1'b1, 8'h77);
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'h4) $display("FAIL flush_wins got %h want 4", dma_io_rdata); else n_pass++;
    wr(A_STAT, 32'h4);
    tick(1'b0, 14'd0, 32'd0, 1'b1, A_DATA, 1'b1, 8'h99);
    n_checks++; if (dma_io_rdata !== 32'h0) $display("FAIL empty_pp_rd got %h want 0", dma_io_rdata); else n_pass++;
    rd(A_DATA);
    n_checks++; if (dma_io_rdata !== 32'h199) $display("FAIL empty_pp_push got %h want 199", dma_io_rdata); else n_pass++;
  endtask

  task automatic test_int();
    wr(A_CTRL, 32'h1);
    n_checks++; if (uart_in_int !== 1'b0) $display("FAIL int_idle got %b want 0", uart_in_int); else n_pass++;
    push(8'h3A);
    n_checks++; if (uart_in_int !== 1'b1) $display("FAIL int_set got %b want 1", uart_in_int); else n_pass++;
    rd(A_CTRL);
    n_checks++; if (dma_io_rdata !== 32'h1) $display("FAIL int_ctrl_rd got %h want 1", dma_io_rdata); else n_pass++;
    rd(A_DATA);
    n_checks++; if (uart_in_int !== 1'b0) $display("FAIL int_clr got %b want 0", uart_in_int); else n_pass++;
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_chain();
    dma_io_rdata_in = 32'h8000_0000;
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'h8000_0000) $display("FAIL chain_stat got %h want 80000000", dma_io_rdata); else n_pass++;
    rd(14'h0001);
    n_checks++; if (dma_io_rdata !== 32'h8000_0000) $display("FAIL chain_unmapped got %h want 80000000", dma_io_rdata); else n_pass++;
    push(8'hC3);
    rd(A_DATA);
    n_checks++; if (dma_io_rdata !== 32'h8000_01C3) $display("FAIL chain_data got %h want 800001c3", dma_io_rdata); else n_pass++;
    dma_io_rdata_in = 32'd0;
  endtask

  task automatic test_random();
    logic [13:0] adrs[4];
    logic we, re, uwe;
    logic [13:0] wadr, radr;
    adrs[0] = A_DATA; adrs[1] = A_STAT; adrs[2] = A_CTRL; adrs[3] = 14'h0123;
    for (int i = 0; i < 400; i++) begin
      we   = ($urandom_range(0, 9) == 0);
      wadr = $urandom_range(0, 1) ? A_CTRL : A_STAT;
      re   = ($urandom_range(0, 2) != 0);
      radr = adrs[$urandom_range(0, 3)];
      uwe  = ($urandom_range(0, 1) == 1);
      dma_io_rdata_in = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'd0;
      tick(we, wadr, 32'($urandom_range(0, 7)), re, radr, uwe, 8'($urandom));
      n_checks++; if (dma_io_rdata !== exp_rdata) $display("FAIL rand_rdata@%0d got %h want %h", i, dma_io_rdata, exp_rdata); else n_pass++;
      n_checks++; if (uart_in_full !== exp_full) $display("FAIL rand_full@%0d got %b want %b", i, uart_in_full, exp_full); else n_pass++;
      n_checks++; if (uart_in_int !== exp_int) $display("FAIL rand_int@%0d got %b want %b", i, uart_in_int, exp_int); else n_pass++;
    end
    dma_io_rdata_in = 32'd0;
    wr(A_CTRL, 32'h2);
    wr(A_STAT, 32'h4);
  endtask

  task automatic test_reset_midread();
    push(8'h11); push(8'h22); push(8'h33);
    rd(A_DATA);
    n_checks++; if (dma_io_rdata !== 32'h111) $display("FAIL rmr_first got %h want 111", dma_io_rdata); else n_pass++;
    dma_io_radr_en = 1'b1;
    dma_io_radr = A_DATA;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (dma_io_rdata !== 32'd0) $display("FAIL rmr_async_rdata got %h want 0", dma_io_rdata); else n_pass++;
    dma_io_radr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (dma_io_rdata !== 32'd0) $display("FAIL rmr_after got %h want 0", dma_io_rdata); else n_pass++;
    n_checks++; if (uart_in_full !== 1'b0) $display("FAIL rmr_full got %b want 0", uart_in_full); else n_pass++;
    rd(A_STAT);
    n_checks++; if (dma_io_rdata !== 32'd0) $display("FAIL rmr_count got %h want 0", dma_io_rdata); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    dma_io_we = 1'b0; dma_io_wadr = 14'd0; dma_io_wdata = 32'd0;
    dma_io_radr_en = 1'b0; dma_io_radr = 14'd0; dma_io_rdata_in = 32'd0;
    uart_in_we = 1'b0; uart_in_char = 8'd0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_corners();
    test_int();
    test_chain();
    test_random();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
